// File: rtl/enc_poll_pkg.sv
// rtl/enc_poll_pkg.sv - shared register map, bit indices and FSM states for enc_poll_sched
package enc_poll_pkg;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_PERIOD = 8'h04;
    localparam logic [7:0] REG_STATUS = 8'h08;
    localparam logic [7:0] REG_POS    = 8'h40;
    localparam logic [7:0] REG_DELTA  = 8'h60;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_TRIG   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_MASK   = 8;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_TIMEOUT = 1;
    localparam int STAT_OVERRUN = 2;
    localparam int STAT_PRIMED  = 3;
    localparam int STAT_DONE    = 4;
    localparam int STAT_COUNT   = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_REQ,
        S_COMMIT
    } state_t;

endpackage

// File: rtl/enc_poll_timer.sv
// rtl/enc_poll_timer.sv - sweep interval down-counter with one-deep pending request and overrun detect
module enc_poll_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_enable,
    input  logic [23:0] i_period,
    input  logic        i_reload,
    input  logic        i_trigger,
    input  logic        i_busy,
    output logic        o_pending,
    output logic        o_overrun_set
);

    logic [23:0] r_cnt;
    logic        r_pending;
    logic        w_tick;

    assign w_tick        = i_enable && (i_period != 24'd0) && !i_reload && (r_cnt == 24'd0);
    assign o_overrun_set = w_tick && i_busy && r_pending;
    assign o_pending     = r_pending;

    // Pending is consumed on the cycle the scheduler is idle and sees it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            if (!i_enable || (i_period == 24'd0) || i_reload || (r_cnt == 24'd0))
                r_cnt <= i_period - 24'd1;
            else
                r_cnt <= r_cnt - 24'd1;
            r_pending <= (r_pending && i_busy) || w_tick || i_trigger;
        end
    end

endmodule

// File: rtl/enc_poll_sched.sv
// rtl/enc_poll_sched.sv - encoder sweep scheduler with CPU register port; ENC_POLL_IRQ_EN adds irq
module enc_poll_sched #(
    parameter int          NUM_ENC   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] STRIDE    = 32'h0000_0010,
    parameter logic [31:0] POS_OFS   = 32'h0000_0000,
    parameter int          TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    output logic        ready,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
`ifdef ENC_POLL_IRQ_EN
    ,
    output logic        irq
`endif
);
    import enc_poll_pkg::*;

    localparam int WW = $clog2(TIMEOUT) + 1;

    state_t               r_state, w_next;
    logic                 r_ready, r_reload, r_enable, r_timeout, r_overrun, r_primed;
    logic [31:0]          r_rdata, r_m_addr, w_rd_mux;
    logic [NUM_ENC-1:0]   r_mask;
    logic [23:0]          r_period;
    logic [7:0]           r_count;
    logic [31:0]          r_pos [NUM_ENC];
    logic [31:0]          r_delta [NUM_ENC];
    logic [31:0]          r_shadow [NUM_ENC];
    logic [3:0]           r_next;
    logic [2:0]           r_cur, w_sel;
    logic [WW-1:0]        r_wait;
    logic                 w_accept, w_wr, w_wr_ctrl, w_wr_period, w_wr_status, w_trigger;
    logic                 w_busy, w_pending, w_overrun_set, w_found, w_ack, w_tmo, w_unused;
    logic [7:0]           w_ofs;
`ifdef ENC_POLL_IRQ_EN
    logic                 r_done, r_irq_en, r_irq;
`endif

    assign w_ofs       = addr[7:0];
    assign w_accept    = valid && !r_ready;
    assign w_wr        = w_accept && (wstrb != 4'b0000);
    assign w_wr_ctrl   = w_wr && (w_ofs == REG_CTRL);
    assign w_wr_period = w_wr && (w_ofs == REG_PERIOD);
    assign w_wr_status = w_wr && (w_ofs == REG_STATUS);
    assign w_trigger   = w_wr_ctrl && wstrb[0] && wdata[CTRL_TRIG];
    assign w_busy      = (r_state != S_IDLE);
    assign w_ack       = (r_state == S_REQ) && m_ready;
    assign w_tmo       = (r_state == S_REQ) && !m_ready && (r_wait == WW'(TIMEOUT - 1));
    assign w_unused    = ^{addr[31:8], wdata[31:24]};

    assign ready   = r_ready;
    assign rdata   = r_rdata;
    assign m_valid = (r_state == S_REQ);
    assign m_addr  = r_m_addr;
    assign m_wstrb = 4'b0000;
    assign m_wdata = 32'h0;

    enc_poll_timer u_timer (
        .clk           (clk),
        .reset         (reset),
        .i_enable      (r_enable),
        .i_period      (r_period),
        .i_reload      (r_reload),
        .i_trigger     (w_trigger),
        .i_busy        (w_busy),
        .o_pending     (w_pending),
        .o_overrun_set (w_overrun_set)
    );

    // Lowest enabled channel at or above the scan pointer; mask is sampled live.
    always_comb begin
        w_found = 1'b0;
        w_sel   = 3'd0;
        for (int i = 0; i < NUM_ENC; i++) begin
            if (!w_found && r_mask[i] && (4'(i) >= r_next)) begin
                w_found = 1'b1;
                w_sel   = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_pending) w_next = S_SCAN;
            S_SCAN:   w_next = w_found ? S_REQ : S_COMMIT;
            S_REQ:    if (w_ack || w_tmo) w_next = S_SCAN;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_mux = 32'h0;
        case (w_ofs)
            REG_CTRL: begin
                w_rd_mux[CTRL_EN]          = r_enable;
                w_rd_mux[CTRL_MASK +: 8]   = 8'(r_mask);
`ifdef ENC_POLL_IRQ_EN
                w_rd_mux[CTRL_IRQ_EN]      = r_irq_en;
`else
                w_rd_mux[CTRL_IRQ_EN]      = 1'b0;
`endif
            end
            REG_PERIOD: w_rd_mux[23:0] = r_period;
            REG_STATUS: begin
                w_rd_mux[STAT_BUSY]        = w_busy;
                w_rd_mux[STAT_TIMEOUT]     = r_timeout;
                w_rd_mux[STAT_OVERRUN]     = r_overrun;
                w_rd_mux[STAT_PRIMED]      = r_primed;
                w_rd_mux[STAT_COUNT +: 8]  = r_count;
`ifdef ENC_POLL_IRQ_EN
                w_rd_mux[STAT_DONE]        = r_done;
`endif
            end
            default: ;
        endcase
        for (int i = 0; i < NUM_ENC; i++) begin
            if (w_ofs == REG_POS + 8'(4 * i))   w_rd_mux = r_pos[i];
            if (w_ofs == REG_DELTA + 8'(4 * i)) w_rd_mux = r_delta[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready   <= 1'b0;
            r_rdata   <= '0;
            r_reload  <= 1'b0;
            r_enable  <= 1'b0;
            r_mask    <= '0;
            r_period  <= '0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
            r_primed  <= 1'b0;
            r_count   <= '0;
            r_next    <= '0;
            r_cur     <= '0;
            r_wait    <= '0;
            r_m_addr  <= '0;
            for (int i = 0; i < NUM_ENC; i++) begin
                r_pos[i]    <= '0;
                r_delta[i]  <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            r_ready  <= w_accept;
            r_rdata  <= (w_accept && (wstrb == 4'b0000)) ? w_rd_mux : 32'h0;
            r_reload <= w_wr_period;
            if (w_wr_ctrl && wstrb[0]) r_enable <= wdata[CTRL_EN];
            if (w_wr_ctrl && wstrb[1]) r_mask   <= wdata[CTRL_MASK +: NUM_ENC];
            for (int b = 0; b < 3; b++)
                if (w_wr_period && wstrb[b]) r_period[8*b +: 8] <= wdata[8*b +: 8];
            // A set event on the same edge as a W1C wins.
            r_timeout <= w_tmo || (r_timeout && !(w_wr_status && wstrb[0] && wdata[STAT_TIMEOUT]));
            r_overrun <= w_overrun_set ||
                         (r_overrun && !(w_wr_status && wstrb[0] && wdata[STAT_OVERRUN]));
            case (r_state)
                S_IDLE: r_next <= '0;
                S_SCAN: begin
                    r_wait <= '0;
                    if (w_found) begin
                        r_cur    <= w_sel;
                        r_next   <= {1'b0, w_sel} + 4'd1;
                        r_m_addr <= BASE_ADDR + STRIDE * {29'b0, w_sel} + POS_OFS;
                    end
                end
                S_REQ: begin
                    r_wait <= r_wait + WW'(1);
                    for (int i = 0; i < NUM_ENC; i++)
                        if (w_ack && (r_cur == 3'(i))) r_shadow[i] <= m_rdata;
                end
                S_COMMIT: begin
                    for (int i = 0; i < NUM_ENC; i++) begin
                        if (r_mask[i]) begin
                            r_delta[i] <= r_shadow[i] - r_pos[i];
                            r_pos[i]   <= r_shadow[i];
                        end
                    end
                    r_count  <= r_count + 8'd1;
                    r_primed <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ENC_POLL_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done   <= 1'b0;
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl && wstrb[0]) r_irq_en <= wdata[CTRL_IRQ_EN];
            if (r_state == S_COMMIT)
                r_done <= 1'b1;
            else if (w_wr_status && wstrb[0] && wdata[STAT_DONE])
                r_done <= 1'b0;
            r_irq <= r_done && r_irq_en;
        end
    end
    assign irq = r_irq;
`endif

endmodule
